// File: rtl/cdb_arb_q_if.sv
// Source-side result handshake and common-data-bus broadcast signals of cdb_arb_q.
interface cdb_arb_q_if #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned ID_W   = 5,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SRC_W = $clog2(N_SRC);

    logic                      flush;
    logic [N_SRC-1:0]          src_req;
    logic [N_SRC-1:0]          src_rdy;
    logic [N_SRC*TAG_W-1:0]    src_tag;
    logic [N_SRC*DATA_W-1:0]   src_wdata;
    logic [N_SRC*ID_W-1:0]     src_inst_id;
    logic                      cdb_wr;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_wdata;
    logic [ID_W-1:0]           cdb_inst_id;
    logic [SRC_W-1:0]          cdb_src;

    modport master (
        output flush, src_req, src_tag, src_wdata, src_inst_id,
        input  src_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src
    );

    modport slave (
        input  flush, src_req, src_tag, src_wdata, src_inst_id,
        output src_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src
    );
endinterface

// File: rtl/cdb_arb_q.sv
// Per-source result queues feeding a single common data bus through a
// fixed-priority (MODE=0) or round-robin (MODE=1) arbiter.
module cdb_arb_q #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned ID_W   = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MODE   = 0
) (
    input  logic       clk,
    input  logic       rst,
    cdb_arb_q_if.slave bus
);
    localparam int unsigned SRC_W = $clog2(N_SRC);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]  tag_mem  [N_SRC][DEPTH];
    logic [DATA_W-1:0] data_mem [N_SRC][DEPTH];
    logic [ID_W-1:0]   id_mem   [N_SRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [N_SRC];
    logic [PTR_W-1:0]  rd_ptr   [N_SRC];
    logic [CNT_W-1:0]  count    [N_SRC];
    logic [SRC_W-1:0]  rr_ptr;

    logic [N_SRC-1:0]  not_full;
    logic [N_SRC-1:0]  not_empty;
    logic [N_SRC-1:0]  push;
    logic [N_SRC-1:0]  pop;
    logic [SRC_W-1:0]  start;
    logic [SRC_W-1:0]  idx;
    logic [SRC_W-1:0]  sel;
    logic              found;
    logic              grant;

    // Occupancy flags come from the count registers only.
    always_comb begin
        not_full  = '0;
        not_empty = '0;
        for (int i = 0; i < N_SRC; i++) begin
            not_full[i]  = (count[i] != CNT_W'(DEPTH));
            not_empty[i] = (count[i] != '0);
        end
    end

    assign start = (MODE == 1) ? rr_ptr : '0;

    // First non-empty queue scanning upward from start, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = SRC_W'((32'(start) + 32'(k)) % N_SRC);
            if (!found && not_empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign grant = found & ~bus.flush & rst;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            push[i] = bus.src_req[i] & not_full[i] & ~bus.flush;
            pop[i]  = grant & (sel == SRC_W'(i));
        end
    end

    assign bus.src_rdy     = not_full & {N_SRC{rst}};
    assign bus.cdb_wr      = grant;
    assign bus.cdb_src     = grant ? sel : '0;
    assign bus.cdb_tag     = grant ? tag_mem[sel][rd_ptr[sel]]  : '0;
    assign bus.cdb_wdata   = grant ? data_mem[sel][rd_ptr[sel]] : '0;
    assign bus.cdb_inst_id = grant ? id_mem[sel][rd_ptr[sel]]   : '0;

    // Queue storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
                data_mem[i][wr_ptr[i]] <= bus.src_wdata[i*DATA_W +: DATA_W];
                id_mem[i][wr_ptr[i]]   <= bus.src_inst_id[i*ID_W +: ID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            if ((MODE == 1) && grant) begin
                rr_ptr <= (sel == SRC_W'(N_SRC - 1)) ? '0 : sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arb_q.sv
// Drives a fixed-priority and a round-robin instance with the same stimulus and
// compares both against queue-based reference models every cycle.
module tb_cdb_arb_q;
    localparam int unsigned N      = 4;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW     = $clog2(N);
    localparam int unsigned EW     = TAG_W + DATA_W + ID_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_arb_q_if #(.N_SRC(N), .TAG_W(TAG_W), .ID_W(ID_W), .DATA_W(DATA_W)) bus0 ();
    cdb_arb_q_if #(.N_SRC(N), .TAG_W(TAG_W), .ID_W(ID_W), .DATA_W(DATA_W)) bus1 ();

    cdb_arb_q #(.N_SRC(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .ID_W(ID_W),
                .DATA_W(DATA_W), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cdb_arb_q #(.N_SRC(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .ID_W(ID_W),
                .DATA_W(DATA_W), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // Reference state: one queue of {tag, data, id} per source per mode.
    logic [EW-1:0] mq [2][N][$];
    int            rrp [2];

    logic [N*TAG_W-1:0]  tg_v;
    logic [N*DATA_W-1:0] dt_v;
    logic [N*ID_W-1:0]   id_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic rnd_fill();
        for (int i = 0; i < N; i++) begin
            tg_v[i*TAG_W +: TAG_W]   = TAG_W'($urandom);
            dt_v[i*DATA_W +: DATA_W] = $urandom;
            id_v[i*ID_W +: ID_W]     = ID_W'($urandom);
        end
    endtask

    // Apply one cycle of inputs, check both DUTs, then advance the models past the edge.
    task automatic step(input logic r, input logic fl, input logic [N-1:0] req);
        logic [N-1:0]      rdy;
        logic              any;
        logic              wr;
        logic              found;
        int                g;
        int                st;
        int                idx;
        logic [EW-1:0]     e;
        logic [N-1:0]      a_rdy;
        logic              a_wr;
        logic [SW-1:0]     a_src;
        logic [TAG_W-1:0]  a_tag;
        logic [DATA_W-1:0] a_dat;
        logic [ID_W-1:0]   a_id;
        @(negedge clk);
        rst = r;
        bus0.flush = fl; bus0.src_req = req;
        bus0.src_tag = tg_v; bus0.src_wdata = dt_v; bus0.src_inst_id = id_v;
        bus1.flush = fl; bus1.src_req = req;
        bus1.src_tag = tg_v; bus1.src_wdata = dt_v; bus1.src_inst_id = id_v;
        #1;
        for (int m = 0; m < 2; m++) begin
            any = 1'b0;
            rdy = '0;
            g   = 0;
            e   = '0;
            for (int i = 0; i < N; i++) begin
                if (mq[m][i].size() != 0) any = 1'b1;
                rdy[i] = r && (mq[m][i].size() != int'(DEPTH));
            end
            wr = r && any && !fl;
            if (wr) begin
                st    = (m == 1) ? rrp[1] : 0;
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (st + k) % N;
                    if (!found && mq[m][idx].size() != 0) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
                e = mq[m][g][0];
            end
            if (m == 0) begin
                a_rdy = bus0.src_rdy; a_wr = bus0.cdb_wr; a_src = bus0.cdb_src;
                a_tag = bus0.cdb_tag; a_dat = bus0.cdb_wdata; a_id = bus0.cdb_inst_id;
            end else begin
                a_rdy = bus1.src_rdy; a_wr = bus1.cdb_wr; a_src = bus1.cdb_src;
                a_tag = bus1.cdb_tag; a_dat = bus1.cdb_wdata; a_id = bus1.cdb_inst_id;
            end
            chk($sformatf("m%0d src_rdy", m), 64'(a_rdy), 64'(rdy));
            chk($sformatf("m%0d cdb_wr", m), 64'(a_wr), 64'(wr));
            chk($sformatf("m%0d cdb_src", m), 64'(a_src), 64'(g));
            chk($sformatf("m%0d cdb_tag", m), 64'(a_tag), 64'(e[EW-1 -: TAG_W]));
            chk($sformatf("m%0d cdb_wdata", m), 64'(a_dat), 64'(e[DATA_W+ID_W-1 -: DATA_W]));
            chk($sformatf("m%0d cdb_inst_id", m), 64'(a_id), 64'(e[ID_W-1:0]));

            if (!r) begin
                for (int i = 0; i < N; i++) mq[m][i].delete();
                rrp[m] = 0;
            end else if (fl) begin
                for (int i = 0; i < N; i++) mq[m][i].delete();
            end else begin
                if (wr) begin
                    e = mq[m][g].pop_front();
                    if (m == 1) rrp[m] = (g + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (req[i] && rdy[i]) begin
                        mq[m][i].push_back({tg_v[i*TAG_W +: TAG_W],
                                            dt_v[i*DATA_W +: DATA_W],
                                            id_v[i*ID_W +: ID_W]});
                    end
                end
            end
        end
    endtask

    initial begin
        bus0.flush = 1'b0; bus0.src_req = '0;
        bus0.src_tag = '0; bus0.src_wdata = '0; bus0.src_inst_id = '0;
        bus1.flush = 1'b0; bus1.src_req = '0;
        bus1.src_tag = '0; bus1.src_wdata = '0; bus1.src_inst_id = '0;
        rrp[0] = 0;
        rrp[1] = 0;
        rnd_fill();

        // Reset hold and release
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '1);
        chk("rst hold src_rdy", 64'(bus0.src_rdy), 64'(0));
        chk("rst hold cdb_wr", 64'(bus1.cdb_wr), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("post rst src_rdy", 64'(bus0.src_rdy), 64'hF);
        chk("post rst cdb_wr", 64'(bus0.cdb_wr), 64'(0));
        chk("post rst cdb_wdata", 64'(bus0.cdb_wdata), 64'(0));

        // Single push on source 2
        rnd_fill();
        tg_v[2*TAG_W +: TAG_W]   = 6'h11;
        dt_v[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
        id_v[2*ID_W +: ID_W]     = 5'd3;
        step(1'b1, 1'b0, 4'b0100);
        step(1'b1, 1'b0, '0);
        chk("single wr", 64'(bus0.cdb_wr), 64'(1));
        chk("single tag", 64'(bus0.cdb_tag), 64'h11);
        chk("single wdata", 64'(bus0.cdb_wdata), 64'hDEADBEEF);
        chk("single id", 64'(bus0.cdb_inst_id), 64'(3));
        chk("single src", 64'(bus0.cdb_src), 64'(2));
        chk("single src rr", 64'(bus1.cdb_src), 64'(2));
        step(1'b1, 1'b0, '0);
        chk("single after wr", 64'(bus0.cdb_wr), 64'(0));

        // Fixed priority: all four sources at once
        rnd_fill();
        step(1'b1, 1'b0, '1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, '0);
            chk($sformatf("prio wr %0d", k), 64'(bus0.cdb_wr), 64'(1));
            chk($sformatf("prio src %0d", k), 64'(bus0.cdb_src), 64'(k));
        end

        // Round robin: sources 0 and 3 request every cycle
        step(1'b0, 1'b0, '0);
        for (int k = 0; k < 8; k++) begin
            rnd_fill();
            step(1'b1, 1'b0, 4'b1001);
            if (k >= 1) begin
                chk($sformatf("rr wr %0d", k), 64'(bus1.cdb_wr), 64'(1));
                chk($sformatf("rr src %0d", k), 64'(bus1.cdb_src), (k % 2 == 1) ? 64'(0) : 64'(3));
            end
        end

        // Source 1 overruns its queue while source 0 keeps priority
        step(1'b0, 1'b0, '0);
        rnd_fill(); tg_v[TAG_W +: TAG_W] = 6'h21;
        step(1'b1, 1'b0, 4'b0011);
        rnd_fill(); tg_v[TAG_W +: TAG_W] = 6'h22;
        step(1'b1, 1'b0, 4'b0011);
        chk("full rdy1 before", 64'(bus0.src_rdy[1]), 64'(1));
        chk("full src b", 64'(bus0.cdb_src), 64'(0));
        rnd_fill(); tg_v[TAG_W +: TAG_W] = 6'h23;
        step(1'b1, 1'b0, 4'b0011);
        chk("full rdy1 after", 64'(bus0.src_rdy[1]), 64'(0));
        chk("full src c", 64'(bus0.cdb_src), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("full src d", 64'(bus0.cdb_src), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("drain1 src", 64'(bus0.cdb_src), 64'(1));
        chk("drain1 tag", 64'(bus0.cdb_tag), 64'h21);
        step(1'b1, 1'b0, '0);
        chk("drain2 src", 64'(bus0.cdb_src), 64'(1));
        chk("drain2 tag", 64'(bus0.cdb_tag), 64'h22);
        step(1'b1, 1'b0, '0);
        chk("drain done wr", 64'(bus0.cdb_wr), 64'(0));

        // Flush with three entries queued
        step(1'b0, 1'b0, '0);
        rnd_fill();
        step(1'b1, 1'b0, 4'b0111);
        step(1'b1, 1'b1, 4'b1000);
        chk("flush cyc wr m0", 64'(bus0.cdb_wr), 64'(0));
        chk("flush cyc wr m1", 64'(bus1.cdb_wr), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("after flush wr", 64'(bus0.cdb_wr), 64'(0));
        chk("after flush rdy", 64'(bus1.src_rdy), 64'hF);

        // Mid-run reset with entries queued and round-robin pointer advanced
        step(1'b0, 1'b0, '0);
        rnd_fill();
        step(1'b1, 1'b0, 4'b0110);
        rnd_fill();
        step(1'b1, 1'b0, 4'b0110);
        step(1'b0, 1'b0, '0);
        chk("midrst rdy", 64'(bus1.src_rdy), 64'(0));
        step(1'b1, 1'b0, '0);
        chk("midrst release wr", 64'(bus1.cdb_wr), 64'(0));
        chk("midrst release rdy", 64'(bus1.src_rdy), 64'hF);
        rnd_fill();
        step(1'b1, 1'b0, 4'b1010);
        step(1'b1, 1'b0, '0);
        chk("midrst rr_ptr zero", 64'(bus1.cdb_src), 64'(1));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rnd_fill();
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 31) == 0),
                 (c < 1500) ? N'($urandom) : (N'($urandom) & N'($urandom)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
